// File: rtl/rvm_pkg.sv
// Shared constants and types for the recycling sorter: status codes, FSM states,
// BCD limit and the classification verdict.
package rvm_pkg;

    localparam logic [2:0] CODE_READY    = 3'd0;
    localparam logic [2:0] CODE_CLASSIFY = 3'd1;
    localparam logic [2:0] CODE_CAN      = 3'd2;
    localparam logic [2:0] CODE_BOTTLE   = 3'd3;
    localparam logic [2:0] CODE_REJECT   = 3'd4;
    localparam logic [2:0] CODE_FULL     = 3'd5;

    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLASSIFY,
        S_ACCEPT,
        S_REJECT,
        S_WAIT_CLEAR
    } state_t;

    typedef struct packed {
        logic       accept;
        logic       inc_can;
        logic       inc_bottle;
        logic [2:0] code;
    } verdict_t;

    // A valid type whose bin is already at BCD_MAX is turned away as "bin full".
    function automatic verdict_t classify(input logic metal, input logic plastic,
                                          input logic [3:0] cans, input logic [3:0] bottles);
        verdict_t v;
        v.accept     = 1'b0;
        v.inc_can    = 1'b0;
        v.inc_bottle = 1'b0;
        v.code       = CODE_REJECT;
        if (metal && !plastic) begin
            if (cans < BCD_MAX) begin
                v.accept  = 1'b1;
                v.inc_can = 1'b1;
                v.code    = CODE_CAN;
            end else begin
                v.code = CODE_FULL;
            end
        end else if (plastic && !metal) begin
            if (bottles < BCD_MAX) begin
                v.accept     = 1'b1;
                v.inc_bottle = 1'b1;
                v.code       = CODE_BOTTLE;
            end else begin
                v.code = CODE_FULL;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/rvm_debounce.sv
// Two-flop synchronizer followed by a debouncer: the output follows the input only
// after DEBOUNCE_CYCLES consecutive cycles of disagreement.
module rvm_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic db_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]       sync_q;
    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Any agreeing cycle drops the count back to zero.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync_q[1] != db_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1))
                db_d = sync_q[1];
            else
                cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q <= '0;
            db_q   <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], async_i};
            db_q   <= db_d;
            cnt_q  <= cnt_d;
        end
    end

    assign db_o = db_q;

endmodule

// File: rtl/rvm_sorter.sv
// Reverse-vending sorter: classifies a chute item as can/bottle/invalid, drives the
// gate or reject flap for HOLD_CYCLES, and keeps saturating BCD bin counts.
module rvm_sorter
    import rvm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       item_present,
    input  logic       metal_detect,
    input  logic       plastic_detect,
    input  logic       clear_btn,
    output logic [2:0] data_out,
    output logic [3:0] can_counter,
    output logic [3:0] bottle_counter,
    output logic       gate_open,
    output logic       reject_out
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int NUM_DB = 2;

    // Lane 0: item sensor, lane 1: clear button.
    logic [NUM_DB-1:0] db_in, db_out, db_prev_q;
    assign db_in = {clear_btn, item_present};

    genvar g;
    generate
        for (g = 0; g < NUM_DB; g++) begin : g_db
            rvm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
                .clk    (clk),
                .reset  (reset),
                .async_i(db_in[g]),
                .db_o   (db_out[g])
            );
        end
    endgenerate

    logic item_db, item_rise, clear_rise;
    assign item_db    = db_out[0];
    assign item_rise  = db_out[0] & ~db_prev_q[0];
    assign clear_rise = db_out[1] & ~db_prev_q[1];

    // Material sensors are only synchronized; {plastic, metal} per stage.
    logic [1:0][1:0] sens_q;

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [2:0]        data_q, data_d;
    logic [3:0]        can_q, can_d, bottle_q, bottle_d;
    logic              gate_q, gate_d, reject_q, reject_d;
    verdict_t          verdict;

    assign verdict = classify(sens_q[1][0], sens_q[1][1], can_q, bottle_q);

    always_ff @(posedge clk) begin
        if (!reset) begin
            db_prev_q <= '0;
            sens_q    <= '0;
            state_q   <= S_IDLE;
            hold_q    <= '0;
            data_q    <= CODE_READY;
            can_q     <= '0;
            bottle_q  <= '0;
            gate_q    <= 1'b0;
            reject_q  <= 1'b0;
        end else begin
            db_prev_q <= db_out;
            sens_q    <= {sens_q[0], {plastic_detect, metal_detect}};
            state_q   <= state_d;
            hold_q    <= hold_d;
            data_q    <= data_d;
            can_q     <= can_d;
            bottle_q  <= bottle_d;
            gate_q    <= gate_d;
            reject_q  <= reject_d;
        end
    end

    // The hold runs to completion regardless of the item sensor.
    always_comb begin
        state_d = state_q;
        hold_d  = '0;
        case (state_q)
            S_IDLE:       if (item_rise) state_d = S_CLASSIFY;
            S_CLASSIFY:   state_d = verdict.accept ? S_ACCEPT : S_REJECT;
            S_ACCEPT,
            S_REJECT: begin
                if (hold_q == HOLD_W'(HOLD_CYCLES - 1))
                    state_d = S_WAIT_CLEAR;
                else
                    hold_d = hold_q + 1'b1;
            end
            S_WAIT_CLEAR: if (!item_db) state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
    end

    always_comb begin
        data_d   = data_q;
        can_d    = can_q;
        bottle_d = bottle_q;
        if (state_q == S_CLASSIFY) begin
            data_d = verdict.code;
            if (verdict.inc_can)    can_d    = can_q + 1'b1;
            if (verdict.inc_bottle) bottle_d = bottle_q + 1'b1;
        end else if (state_d == S_CLASSIFY) begin
            data_d = CODE_CLASSIFY;
        end else if (state_d == S_IDLE) begin
            data_d = (can_q == BCD_MAX && bottle_q == BCD_MAX) ? CODE_FULL : CODE_READY;
        end
        if (clear_rise) begin
            can_d    = '0;
            bottle_d = '0;
        end
        gate_d   = (state_d == S_ACCEPT);
        reject_d = (state_d == S_REJECT);
    end

    assign data_out       = data_q;
    assign can_counter    = can_q;
    assign bottle_counter = bottle_q;
    assign gate_open      = gate_q;
    assign reject_out     = reject_q;

endmodule

// File: tb/tb_rvm_sorter.sv
// Scoreboard bench for rvm_sorter with short debounce/hold settings.
module tb_rvm_sorter;

    localparam int DB   = 4;
    localparam int HOLD = 8;
    localparam int LIM  = 60;

    logic       clk = 1'b0;
    logic       reset, item_present, metal_detect, plastic_detect, clear_btn;
    logic [2:0] data_out;
    logic [3:0] can_counter, bottle_counter;
    logic       gate_open, reject_out;

    rvm_sorter #(.DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HOLD)) dut (
        .clk           (clk),
        .reset         (reset),
        .item_present  (item_present),
        .metal_detect  (metal_detect),
        .plastic_detect(plastic_detect),
        .clear_btn     (clear_btn),
        .data_out      (data_out),
        .can_counter   (can_counter),
        .bottle_counter(bottle_counter),
        .gate_open     (gate_open),
        .reject_out    (reject_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] code;
        logic [3:0] cans;
        logic [3:0] bottles;
        logic       acc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   can_m = 0;
    int   bottle_m = 0;

    // Reference model of one classification; updates the model counters.
    task automatic predict(input logic m, input logic p, output exp_t e);
        e.acc  = 1'b0;
        e.code = 3'd4;
        if (m && !p) begin
            if (can_m < 9) begin e.code = 3'd2; e.acc = 1'b1; can_m++; end
            else e.code = 3'd5;
        end else if (p && !m) begin
            if (bottle_m < 9) begin e.code = 3'd3; e.acc = 1'b1; bottle_m++; end
            else e.code = 3'd5;
        end
        e.cans    = 4'(can_m);
        e.bottles = 4'(bottle_m);
    endtask

    function automatic logic [2:0] idle_code();
        return (can_m == 9 && bottle_m == 9) ? 3'd5 : 3'd0;
    endfunction

    task automatic wait_code(input logic [2:0] code, output bit ok);
        int t = 0;
        while (data_out !== code && t < LIM) begin @(negedge clk); t++; end
        ok = (data_out === code);
    endtask

    // Inserts one item and checks decision, counters, hold length and return to idle.
    task automatic insert(input string nm, input logic m, input logic p, input bit early_release);
        exp_t e;
        bit   ok, both, other;
        int   hi;
        predict(m, p, e);
        sb.push_back(e);
        @(negedge clk);
        metal_detect = m; plastic_detect = p; item_present = 1'b1;
        wait_code(3'd1, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL %s classify: data_out=%0d required 1", nm, data_out); end
        @(negedge clk);
        e = sb.pop_front();
        if (early_release) item_present = 1'b0;
        n_cmp++;
        if (data_out !== e.code) begin n_err++; $display("FAIL %s code: got %0d required %0d", nm, data_out, e.code); end
        n_cmp++;
        if (can_counter !== e.cans) begin n_err++; $display("FAIL %s cans: got %0d required %0d", nm, can_counter, e.cans); end
        n_cmp++;
        if (bottle_counter !== e.bottles) begin n_err++; $display("FAIL %s bottles: got %0d required %0d", nm, bottle_counter, e.bottles); end
        hi = 0; both = 0; other = 0;
        while (((e.acc ? gate_open : reject_out) === 1'b1) && hi < 30) begin
            if (gate_open && reject_out) both = 1;
            if (e.acc ? reject_out : gate_open) other = 1;
            hi++;
            @(negedge clk);
        end
        n_cmp++;
        if (hi != HOLD) begin n_err++; $display("FAIL %s hold: %0d cycles required %0d", nm, hi, HOLD); end
        n_cmp++;
        if (both || other) begin n_err++; $display("FAIL %s actuators: both=%0b wrong=%0b required 0/0", nm, both, other); end
        item_present = 1'b0;
        wait_code(idle_code(), ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL %s idle: data_out=%0d required %0d", nm, data_out, idle_code()); end
        repeat (DB + 4) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; item_present = 0; metal_detect = 0; plastic_detect = 0; clear_btn = 0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (data_out !== 3'd0) begin n_err++; $display("FAIL reset data_out: got %0d required 0", data_out); end
        n_cmp++;
        if (can_counter !== 4'd0 || bottle_counter !== 4'd0) begin
            n_err++; $display("FAIL reset counters: got %0d/%0d required 0/0", can_counter, bottle_counter);
        end
        n_cmp++;
        if (gate_open !== 1'b0 || reject_out !== 1'b0) begin
            n_err++; $display("FAIL reset actuators: got %0b/%0b required 0/0", gate_open, reject_out);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_can();
        insert("can", 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_bounce();
        bit moved = 0;
        for (int i = 0; i < 20 + DB + 6; i++) begin
            @(negedge clk);
            if (data_out !== 3'd0 || gate_open || reject_out) moved = 1;
            item_present = (i < 20) ? (((i / 2) % 2) == 0) : 1'b0;
        end
        n_cmp++;
        if (moved) begin n_err++; $display("FAIL bounce: FSM left idle, data_out=%0d required 0", data_out); end
        n_cmp++;
        if (can_counter !== 4'(can_m) || bottle_counter !== 4'(bottle_m)) begin
            n_err++; $display("FAIL bounce counters: got %0d/%0d required %0d/%0d", can_counter, bottle_counter, can_m, bottle_m);
        end
    endtask

    task automatic test_invalid();
        insert("invalid_mp", 1'b1, 1'b1, 1'b0);
        insert("invalid_none", 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 10; i++) insert($sformatf("bottle%0d", i), 1'b0, 1'b1, (i % 2) == 1);
    endtask

    task automatic test_back_to_back();
        insert("can_b2b", 1'b1, 1'b0, 1'b1);
    endtask

    // Clear trails the item by one cycle so its debounced edge meets the CLASSIFY cycle.
    task automatic test_clear();
        exp_t e;
        bit   ok;
        predict(1'b1, 1'b0, e);
        sb.push_back(e);
        @(negedge clk);
        metal_detect = 1'b1; plastic_detect = 1'b0; item_present = 1'b1;
        @(negedge clk);
        clear_btn = 1'b1;
        wait_code(3'd1, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL clear classify: data_out=%0d required 1", data_out); end
        @(negedge clk);
        e = sb.pop_front();
        can_m = 0; bottle_m = 0;
        n_cmp++;
        if (data_out !== e.code) begin n_err++; $display("FAIL clear code: got %0d required %0d", data_out, e.code); end
        n_cmp++;
        if (can_counter !== 4'd0 || bottle_counter !== 4'd0) begin
            n_err++; $display("FAIL clear counters: got %0d/%0d required 0/0", can_counter, bottle_counter);
        end
        item_present = 1'b0; clear_btn = 1'b0;
        wait_code(3'd0, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL clear idle: data_out=%0d required 0", data_out); end
        repeat (DB + 4) @(negedge clk);
    endtask

    task automatic test_reset_mid_hold();
        exp_t e;
        bit   ok;
        predict(1'b1, 1'b0, e);
        sb.push_back(e);
        @(negedge clk);
        metal_detect = 1'b1; plastic_detect = 1'b0; item_present = 1'b1;
        wait_code(3'd1, ok);
        @(negedge clk);
        e = sb.pop_front();
        n_cmp++;
        if (gate_open !== 1'b1 || data_out !== e.code) begin
            n_err++; $display("FAIL rst_hold accept: gate=%0b code=%0d required 1/%0d", gate_open, data_out, e.code);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0; item_present = 1'b0;
        can_m = 0; bottle_m = 0;
        @(negedge clk);
        n_cmp++;
        if (gate_open !== 1'b0 || reject_out !== 1'b0) begin
            n_err++; $display("FAIL rst_hold actuators: got %0b/%0b required 0/0", gate_open, reject_out);
        end
        n_cmp++;
        if (data_out !== 3'd0 || can_counter !== 4'd0 || bottle_counter !== 4'd0) begin
            n_err++; $display("FAIL rst_hold outputs: got %0d/%0d/%0d required 0/0/0", data_out, can_counter, bottle_counter);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (DB + 4) @(negedge clk);
        insert("can_after_reset", 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_can();
        test_bounce();
        test_invalid();
        test_saturation();
        test_back_to_back();
        test_clear();
        test_reset_mid_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/rvm_sorter.md
RVM_SORTER -- requirements
Module: rvm_sorter

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, is the number of stable cycles before a debounced input changes (10 ms at 100 MHz).
REQ-002 Parameter HOLD_CYCLES, default 50000000, is the number of cycles the gate or reject actuator is held asserted.
REQ-003 Port clk, input, 1 bit, is the single system clock; all logic SHALL be on its rising edge.
REQ-004 Port reset, input, 1 bit, is the synchronous, active-low reset.
REQ-005 Port item_present, input, 1 bit, is the asynchronous chute sensor; 1 means an item is in the chute.
REQ-006 Port metal_detect, input, 1 bit, is the asynchronous inductive sensor; 1 means metal.
REQ-007 Port plastic_detect, input, 1 bit, is the asynchronous optical sensor; 1 means PET.
REQ-008 Port clear_btn, input, 1 bit, is the asynchronous operator clear button.
REQ-009 Port data_out, output, 3 bits, is the status code: 0 ready, 1 classifying, 2 can accepted, 3 bottle accepted, 4 rejected, 5 bin full.
REQ-010 Port can_counter, output, 4 bits, is the BCD count of accepted cans, 0-9.
REQ-011 Port bottle_counter, output, 4 bits, is the BCD count of accepted bottles, 0-9.
REQ-012 Port gate_open, output, 1 bit, drives the accept-gate actuator.
REQ-013 Port reject_out, output, 1 bit, drives the reject-flap actuator.

Function
REQ-014 All four asynchronous inputs SHALL pass through a 2-flop synchronizer.
REQ-015 item_present and clear_btn SHALL also be debounced: a debounced value takes the synchronized value after DEBOUNCE_CYCLES consecutive cycles of disagreement; any agreeing cycle restarts the count.
REQ-016 The FSM SHALL have five states: IDLE, CLASSIFY, ACCEPT, REJECT, WAIT_CLEAR.
REQ-017 In IDLE, a debounced item rising edge SHALL move the FSM to CLASSIFY for exactly one cycle, with data_out=1.
REQ-018 CLASSIFY SHALL sample the synchronized metal and plastic values and decide the outcome:
- metal=1, plastic=0 -> can; plastic=1, metal=0 -> bottle; any other combination -> invalid.
- can with can_counter<9 -> ACCEPT, data_out=2, can_counter+1.
- bottle with bottle_counter<9 -> ACCEPT, data_out=3, bottle_counter+1.
- valid type with its counter=9 -> REJECT, data_out=5, no increment.
- invalid -> REJECT, data_out=4.
REQ-019 Each counter SHALL saturate at 9 and never wrap.
REQ-020 ACCEPT SHALL hold gate_open=1 for exactly HOLD_CYCLES cycles, then go to WAIT_CLEAR.
REQ-021 REJECT SHALL hold reject_out=1 for exactly HOLD_CYCLES cycles, then go to WAIT_CLEAR.
REQ-022 gate_open and reject_out SHALL never be 1 in the same cycle.
REQ-023 WAIT_CLEAR SHALL keep data_out unchanged and go to IDLE on the first cycle the debounced item is 0.
REQ-024 In IDLE, data_out SHALL be 5 when both counters are 9, otherwise 0.
REQ-025 A debounced clear_btn rising edge SHALL zero both counters on the next cycle in any state; if it coincides with an increment, clear wins.
REQ-026 An item removed during ACCEPT or REJECT SHALL NOT shorten the hold.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 While reset=0 at a clock edge, the block SHALL set state=IDLE, data_out=0, both counters=0, gate_open=0, reject_out=0, and clear all synchronizer, debounce and hold counters.
REQ-029 A reset asserted mid-hold SHALL deassert the actuator on the following edge.

Structure
REQ-030 Package rvm_pkg SHALL hold the status-code constants (0-5), the FSM state type, and the BCD maximum (9); the display block SHALL share these.
REQ-031 One sub-module, rvm_debounce (synchronizer plus debounce, parameter DEBOUNCE_CYCLES), SHALL be instantiated for item_present and for clear_btn.
REQ-032 The hold counter width SHALL be $clog2(HOLD_CYCLES+1).

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=8)
REQ-033 Can path: item=1, metal=1, plastic=0 -> data_out 1 then 2, can_counter 0->1, gate_open high for exactly 8 cycles; item=0 -> data_out=0.
REQ-034 Bounce filter: item toggles every 2 cycles for 20 cycles -> FSM stays IDLE, no counter change.
REQ-035 Saturation: 10 bottles inserted -> bottle_counter=9 after the 9th; the 10th gives data_out=5, reject_out high for 8 cycles, counter still 9.
REQ-036 Invalid item: metal=1, plastic=1 -> data_out=4, reject_out high for 8 cycles, both counters unchanged.
REQ-037 Clear during increment: clear_btn debounced edge lands on the CLASSIFY accept cycle -> both counters=0 on the next cycle.
REQ-038 Reset at cycle 3 of ACCEPT -> gate_open=0, all outputs at reset values on the next edge.
